// File: rtl/ysyx_23060025_axi_sram_slave.sv
// AXI4-Lite SRAM responder: one outstanding transaction, fixed per-direction latency.
// Decodes byte addresses to a word-addressed array and answers SLVERR for out-of-range/misaligned accesses.
module ysyx_23060025_axi_sram_slave #(
    parameter int                  DATA_LEN   = 32,
    parameter int                  ADDR_LEN   = 32,
    parameter int                  DEPTH      = 1024,
    parameter logic [ADDR_LEN-1:0] ADDR_BASE  = 32'h8000_0000,
    parameter int                  RD_LATENCY = 0,
    parameter int                  WR_LATENCY = 0
) (
    input  logic                clock,
    input  logic                rstn,

    input  logic [ADDR_LEN-1:0] addr_r_addr_i,
    input  logic [2:0]          addr_r_size_i,
    input  logic                addr_r_valid_i,
    output logic                addr_r_ready_o,

    output logic [DATA_LEN-1:0] r_data_o,
    output logic [1:0]          r_resp_o,
    output logic                r_valid_o,
    input  logic                r_ready_i,

    input  logic [ADDR_LEN-1:0] addr_w_addr_i,
    input  logic [2:0]          addr_w_size_i,
    input  logic                addr_w_valid_i,
    output logic                addr_w_ready_o,

    input  logic [DATA_LEN-1:0] w_data_i,
    input  logic [3:0]          w_strb_i,
    input  logic                w_valid_i,
    output logic                w_ready_o,

    output logic [1:0]          bkwd_resp_o,
    output logic                bkwd_valid_o,
    input  logic                bkwd_ready_i
);

    localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] RD_LAT      = 4'(RD_LATENCY);
    localparam logic [3:0] WR_LAT      = 4'(WR_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          cnt;
    logic [3:0]          cnt_next;
    logic [3:0]          cnt_inc;

    logic [DATA_LEN-1:0] mem [DEPTH];

    logic                idle;
    logic                wr_both;
    logic                wr_fire;
    logic                rd_fire;
    logic                rd_err;
    logic                wr_err;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;

    // An access is an error when it falls outside the array or is not naturally aligned.
    function automatic logic is_slverr(input logic [ADDR_LEN-1:0] addr,
                                       input logic [2:0]          size);
        logic [ADDR_LEN-1:0] align_mask;
        logic                below;
        logic                beyond;
        logic                bad_size;
        logic                misaligned;
        align_mask = (ADDR_LEN'(1) << size) - ADDR_LEN'(1);
        below      = (addr < ADDR_BASE);
        beyond     = (((addr - ADDR_BASE) >> 2) >= ADDR_LEN'(DEPTH));
        bad_size   = (size > 3'd2);
        misaligned = ((addr & align_mask) != '0);
        return below | beyond | bad_size | misaligned;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_LEN-1:0] addr);
        return IDX_W'((addr - ADDR_BASE) >> 2);
    endfunction

    assign idle    = (state == IDLE);
    assign wr_both = addr_w_valid_i & w_valid_i;

    // Readies are gated by rstn so nothing is accepted (or written) while reset is held.
    assign wr_fire = rstn & idle & wr_both;
    assign rd_fire = rstn & idle & addr_r_valid_i & ~wr_both;

    assign addr_w_ready_o = wr_fire;
    assign w_ready_o      = wr_fire;
    assign addr_r_ready_o = rd_fire;

    assign rd_err  = is_slverr(addr_r_addr_i, addr_r_size_i);
    assign wr_err  = is_slverr(addr_w_addr_i, addr_w_size_i);
    assign rd_idx  = word_index(addr_r_addr_i);
    assign wr_idx  = word_index(addr_w_addr_i);
    assign cnt_inc = cnt + 4'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next   = state;
        cnt_next     = cnt;
        r_valid_o    = 1'b0;
        bkwd_valid_o = 1'b0;
        case (state)
            IDLE: begin
                if (wr_fire) begin
                    state_next = (WR_LAT != 4'd0) ? WR_WAIT : WR_RESP;
                end else if (rd_fire) begin
                    state_next = (RD_LAT != 4'd0) ? RD_WAIT : RD_RESP;
                end
            end
            RD_WAIT: begin
                if (cnt_inc == RD_LAT) begin
                    state_next = RD_RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            RD_RESP: begin
                r_valid_o = 1'b1;
                if (r_ready_i) begin
                    state_next = IDLE;
                end
            end
            WR_WAIT: begin
                if (cnt_inc == WR_LAT) begin
                    state_next = WR_RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            WR_RESP: begin
                bkwd_valid_o = 1'b1;
                if (bkwd_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            r_data_o    <= '0;
            r_resp_o    <= RESP_OKAY;
            bkwd_resp_o <= RESP_OKAY;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (rd_fire) begin
                r_data_o <= rd_err ? '0 : mem[rd_idx];
                r_resp_o <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (wr_fire) begin
                bkwd_resp_o <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // NOTE: the array has no reset; its contents survive rstn and only strobed bytes ever change.
    always_ff @(posedge clock) begin
        if (wr_fire && !wr_err) begin
            for (int n = 0; n < 4; n++) begin
                if (w_strb_i[n]) begin
                    mem[wr_idx][8*n +: 8] <= w_data_i[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_axi_sram_slave.sv
// Bench for the AXI4-Lite SRAM slave: directed cases plus randomized traffic on two
// instances (zero latency, and RD=3/WR=4), checked against a byte-level memory model.
module tb_ysyx_23060025_axi_sram_slave;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clock = 1'b0;
    logic rstn  = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] ar_addr  [2];
    logic [2:0]  ar_size  [2];
    logic        ar_valid [2];
    logic        ar_ready [2];
    logic [31:0] r_data   [2];
    logic [1:0]  r_resp   [2];
    logic        r_valid  [2];
    logic        r_ready  [2];
    logic [31:0] aw_addr  [2];
    logic [2:0]  aw_size  [2];
    logic        aw_valid [2];
    logic        aw_ready [2];
    logic [31:0] w_data   [2];
    logic [3:0]  w_strb   [2];
    logic        w_valid  [2];
    logic        w_ready  [2];
    logic [1:0]  b_resp   [2];
    logic        b_valid  [2];
    logic        b_ready  [2];

    int rd_lat [2] = '{0, 3};
    int wr_lat [2] = '{0, 4};

    // Reference memory: word values plus a flag saying every byte of the word is defined.
    bit [31:0] mdl   [2][DEPTH];
    bit        known [2][DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    ysyx_23060025_axi_sram_slave #(.DEPTH(DEPTH), .ADDR_BASE(BASE), .RD_LATENCY(0), .WR_LATENCY(0)) dut0 (
        .clock(clock), .rstn(rstn),
        .addr_r_addr_i(ar_addr[0]), .addr_r_size_i(ar_size[0]), .addr_r_valid_i(ar_valid[0]), .addr_r_ready_o(ar_ready[0]),
        .r_data_o(r_data[0]), .r_resp_o(r_resp[0]), .r_valid_o(r_valid[0]), .r_ready_i(r_ready[0]),
        .addr_w_addr_i(aw_addr[0]), .addr_w_size_i(aw_size[0]), .addr_w_valid_i(aw_valid[0]), .addr_w_ready_o(aw_ready[0]),
        .w_data_i(w_data[0]), .w_strb_i(w_strb[0]), .w_valid_i(w_valid[0]), .w_ready_o(w_ready[0]),
        .bkwd_resp_o(b_resp[0]), .bkwd_valid_o(b_valid[0]), .bkwd_ready_i(b_ready[0])
    );

    ysyx_23060025_axi_sram_slave #(.DEPTH(DEPTH), .ADDR_BASE(BASE), .RD_LATENCY(3), .WR_LATENCY(4)) dut1 (
        .clock(clock), .rstn(rstn),
        .addr_r_addr_i(ar_addr[1]), .addr_r_size_i(ar_size[1]), .addr_r_valid_i(ar_valid[1]), .addr_r_ready_o(ar_ready[1]),
        .r_data_o(r_data[1]), .r_resp_o(r_resp[1]), .r_valid_o(r_valid[1]), .r_ready_i(r_ready[1]),
        .addr_w_addr_i(aw_addr[1]), .addr_w_size_i(aw_size[1]), .addr_w_valid_i(aw_valid[1]), .addr_w_ready_o(aw_ready[1]),
        .w_data_i(w_data[1]), .w_strb_i(w_strb[1]), .w_valid_i(w_valid[1]), .w_ready_o(w_ready[1]),
        .bkwd_resp_o(b_resp[1]), .bkwd_valid_o(b_valid[1]), .bkwd_ready_i(b_ready[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input logic [31:0] addr, input logic [2:0] size);
        longint a;
        a = 0;
        a[31:0] = addr;
        if (a < longint'(BASE)) return 1'b1;
        if ((a - longint'(BASE)) / 4 >= DEPTH) return 1'b1;
        if (size > 3'd2) return 1'b1;
        if (a % (longint'(1) << size) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int word_idx(input logic [31:0] addr);
        longint a;
        a = 0;
        a[31:0] = addr;
        return int'((a - longint'(BASE)) / 4);
    endfunction

    task automatic model_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] data, input logic [3:0] strb);
        int idx;
        if (!exp_err(addr, size)) begin
            idx = word_idx(addr);
            for (int n = 0; n < 4; n++) begin
                if (strb[n]) mdl[d][idx][8*n +: 8] = data[8*n +: 8];
            end
            if (strb == 4'hF) known[d][idx] = 1'b1;
        end
    endtask

    task automatic wait_b(input int d, output int k);
        k = 1;
        @(negedge clock);
        while (b_valid[d] !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic wait_r(input int d, output int k);
        k = 1;
        @(negedge clock);
        while (r_valid[d] !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
    endtask

    // Called at a negedge with B valid; holds bready low, then completes the handshake.
    task automatic finish_b(input int d, input int hold);
        bit         stable;
        logic [1:0] resp0;
        stable = 1'b1;
        resp0  = b_resp[d];
        repeat (hold) begin
            @(negedge clock);
            if (b_valid[d] !== 1'b1 || b_resp[d] !== resp0) stable = 1'b0;
        end
        if (hold > 0) check("b_hold_stable", 32'(stable), 32'd1);
        b_ready[d] = 1'b1;
        @(posedge clock);
        #1;
        b_ready[d] = 1'b0;
        check("b_valid_clear", 32'(b_valid[d]), 32'd0);
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, input logic [3:0] strb, input int hold);
        bit err;
        int k;
        err = exp_err(addr, size);
        @(negedge clock);
        aw_addr[d] = addr; aw_size[d] = size; w_data[d] = data; w_strb[d] = strb;
        aw_valid[d] = 1'b1; w_valid[d] = 1'b1; b_ready[d] = 1'b0;
        #1;
        check("aw_ready", 32'(aw_ready[d]), 32'd1);
        check("w_ready", 32'(w_ready[d]), 32'd1);
        @(posedge clock);
        #1;
        aw_valid[d] = 1'b0; w_valid[d] = 1'b0;
        model_write(d, addr, size, data, strb);
        wait_b(d, k);
        check("b_latency", 32'(k), 32'(wr_lat[d] + 1));
        check("b_resp", 32'(b_resp[d]), err ? 32'd2 : 32'd0);
        finish_b(d, hold);
    endtask

    task automatic do_read(input int d, input logic [31:0] addr, input logic [2:0] size, input int hold);
        bit          err;
        bit          chk_data;
        bit          stable;
        int          k;
        int          idx;
        logic [31:0] exp_data;
        logic [31:0] data0;
        err      = exp_err(addr, size);
        chk_data = 1'b1;
        exp_data = 32'd0;
        if (!err) begin
            idx      = word_idx(addr);
            chk_data = known[d][idx];
            exp_data = mdl[d][idx];
        end
        @(negedge clock);
        ar_addr[d] = addr; ar_size[d] = size; ar_valid[d] = 1'b1; r_ready[d] = 1'b0;
        #1;
        check("ar_ready", 32'(ar_ready[d]), 32'd1);
        @(posedge clock);
        #1;
        ar_valid[d] = 1'b0;
        wait_r(d, k);
        check("r_latency", 32'(k), 32'(rd_lat[d] + 1));
        check("r_resp", 32'(r_resp[d]), err ? 32'd2 : 32'd0);
        if (chk_data) check("r_data", r_data[d], exp_data);
        stable = 1'b1;
        data0  = r_data[d];
        repeat (hold) begin
            @(negedge clock);
            if (r_valid[d] !== 1'b1 || r_data[d] !== data0) stable = 1'b0;
        end
        if (hold > 0) check("r_hold_stable", 32'(stable), 32'd1);
        r_ready[d] = 1'b1;
        @(posedge clock);
        #1;
        r_ready[d] = 1'b0;
        check("r_valid_clear", 32'(r_valid[d]), 32'd0);
    endtask

    task automatic check_outputs_zero(input int d);
        check("rst_r_valid", 32'(r_valid[d]), 32'd0);
        check("rst_b_valid", 32'(b_valid[d]), 32'd0);
        check("rst_r_data", r_data[d], 32'd0);
        check("rst_r_resp", 32'(r_resp[d]), 32'd0);
        check("rst_b_resp", 32'(b_resp[d]), 32'd0);
        check("rst_readies", {29'd0, ar_ready[d], aw_ready[d], w_ready[d]}, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            7:       return BASE - 32'(4 * $urandom_range(1, 4));
            8:       return BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
            9:       return BASE + 32'((DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
            default: return BASE + 32'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k;
        bit          seen;
        logic [31:0] a;

        for (int d = 0; d < 2; d++) begin
            ar_addr[d] = '0; ar_size[d] = '0; ar_valid[d] = 1'b0; r_ready[d] = 1'b0;
            aw_addr[d] = '0; aw_size[d] = '0; aw_valid[d] = 1'b0;
            w_data[d] = '0; w_strb[d] = '0; w_valid[d] = 1'b0; b_ready[d] = 1'b0;
        end

        // Reset state
        #2;
        check_outputs_zero(0);
        check_outputs_zero(1);
        repeat (3) @(negedge clock);
        rstn = 1'b1;

        // Define a working set of words in both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) do_write(d, BASE + 32'(4 * i), 3'd2, $urandom, 4'hF, 0);
            do_write(d, BASE + 32'((DEPTH - 1) * 4), 3'd2, $urandom, 4'hF, 0);
        end

        // Word write then read, zero latency
        do_write(0, 32'h8000_0010, 3'd2, 32'hDEAD_BEEF, 4'hF, 0);
        do_read(0, 32'h8000_0010, 3'd2, 0);

        // Byte write into lane 3
        do_write(0, 32'h8000_0013, 3'd0, 32'hAB00_0000, 4'h8, 0);
        do_read(0, 32'h8000_0010, 3'd2, 0);
        check("sb_merge_model", mdl[0][4], 32'hABAD_BEEF);

        // Error decodes
        do_read(0, 32'h7FFF_FFFC, 3'd2, 0);
        do_read(0, 32'h8000_0001, 3'd1, 0);
        do_read(0, 32'h8000_0000, 3'd3, 0);
        do_write(0, BASE + 32'(DEPTH * 4), 3'd2, 32'h5555_AAAA, 4'hF, 0);
        do_read(0, BASE, 3'd2, 0);
        do_read(0, BASE + 32'((DEPTH - 1) * 4), 3'd2, 0);

        // Zero strobe still answers OKAY and leaves the word untouched
        do_write(0, 32'h8000_0010, 3'd2, 32'h1234_5678, 4'h0, 0);
        do_read(0, 32'h8000_0010, 3'd2, 0);

        // Latency instance: read with rready held low 5 cycles, then back-to-back accept
        do_write(1, 32'h8000_0020, 3'd2, 32'hCAFE_F00D, 4'hF, 2);
        do_read(1, 32'h8000_0020, 3'd2, 5);
        do_read(1, 32'h8000_0024, 3'd2, 0);

        // AR, AW and W presented together: the write goes first, the read then sees it
        @(negedge clock);
        a = 32'h8000_0028;
        ar_addr[1] = a; ar_size[1] = 3'd2; ar_valid[1] = 1'b1;
        aw_addr[1] = a; aw_size[1] = 3'd2; w_data[1] = 32'h0BAD_CAFE; w_strb[1] = 4'hF;
        aw_valid[1] = 1'b1; w_valid[1] = 1'b1;
        #1;
        check("prio_aw_ready", 32'(aw_ready[1]), 32'd1);
        check("prio_ar_ready", 32'(ar_ready[1]), 32'd0);
        @(posedge clock);
        #1;
        aw_valid[1] = 1'b0; w_valid[1] = 1'b0;
        model_write(1, a, 3'd2, 32'h0BAD_CAFE, 4'hF);
        seen = 1'b0;
        k = 1;
        @(negedge clock);
        while (b_valid[1] !== 1'b1 && k < 40) begin
            if (ar_ready[1] !== 1'b0) seen = 1'b1;
            @(negedge clock);
            k++;
        end
        check("prio_ar_blocked", 32'(seen), 32'd0);
        check("prio_b_latency", 32'(k), 32'(wr_lat[1] + 1));
        finish_b(1, 0);
        @(negedge clock);
        #1;
        check("prio_ar_after", 32'(ar_ready[1]), 32'd1);
        @(posedge clock);
        #1;
        ar_valid[1] = 1'b0;
        wait_r(1, k);
        check("prio_r_latency", 32'(k), 32'(rd_lat[1] + 1));
        check("prio_r_data", r_data[1], 32'h0BAD_CAFE);
        r_ready[1] = 1'b1;
        @(posedge clock);
        #1;
        r_ready[1] = 1'b0;

        // Reset while the latency instance waits to answer a write
        @(negedge clock);
        a = 32'h8000_0030;
        aw_addr[1] = a; aw_size[1] = 3'd2; w_data[1] = 32'h7654_3210; w_strb[1] = 4'hF;
        aw_valid[1] = 1'b1; w_valid[1] = 1'b1;
        @(posedge clock);
        #1;
        aw_valid[1] = 1'b0; w_valid[1] = 1'b0;
        model_write(1, a, 3'd2, 32'h7654_3210, 4'hF);
        repeat (2) @(negedge clock);
        rstn = 1'b0;
        #1;
        check_outputs_zero(1);
        check_outputs_zero(0);
        repeat (2) @(negedge clock);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (b_valid[1] !== 1'b0) seen = 1'b1;
        end
        check("no_b_after_reset", 32'(seen), 32'd0);
        do_read(1, a, 3'd2, 0);

        // AW alone, then W alone, must never be accepted
        @(negedge clock);
        aw_addr[0] = BASE; aw_size[0] = 3'd2; aw_valid[0] = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clock);
            #1;
            if (aw_ready[0] !== 1'b0 || w_ready[0] !== 1'b0) seen = 1'b1;
        end
        check("aw_alone_ready", 32'(seen), 32'd0);
        aw_valid[0] = 1'b0; w_valid[0] = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clock);
            #1;
            if (aw_ready[0] !== 1'b0 || w_ready[0] !== 1'b0) seen = 1'b1;
        end
        check("w_alone_ready", 32'(seen), 32'd0);
        w_valid[0] = 1'b0;

        // Randomized traffic on both instances
        for (int i = 0; i < 40; i++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 1) == 1)
                    do_write(d, rand_addr(), 3'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 2));
                else
                    do_read(d, rand_addr(), 3'($urandom_range(0, 3)), $urandom_range(0, 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
